// File: rtl/pipelined_prefix_adder.sv
// WIDTH-bit Kogge-Stone adder/subtractor whose prefix levels are spread over
// STAGES register stages, with a valid/ready handshake on both ends.
module pipelined_prefix_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] term0,
    input  logic [WIDTH-1:0] term1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int L = $clog2(WIDTH);
    localparam int D = 1 << (L - 1);

    // Register boundary k (1..STAGES-1) sits after logical level cut_level(k).
    function automatic int cut_level(input int k);
        return (k * (L + 1)) / STAGES - 1;
    endfunction

    function automatic int stage_at(input int lvl);
        int r;
        r = -1;
        for (int k = 1; k < STAGES; k++)
            if (cut_level(k) == lvl) r = k - 1;
        return r;
    endfunction

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] raw;
        logic             c0;
        logic             sa;
        logic             sb;
    } pp_t;

    // Level 0: carry-in is folded into the bit-0 generate.
    pp_t              pre;
    logic [WIDTH-1:0] bm;
    always_comb begin
        bm       = sub ? ~term1 : term1;
        pre.c0   = cin ^ sub;
        pre.raw  = term0 ^ bm;
        pre.p    = pre.raw;
        pre.g    = term0 & bm;
        pre.g[0] = pre.g[0] | (pre.raw[0] & pre.c0);
        pre.sa   = term0[WIDTH-1];
        pre.sb   = bm[WIDTH-1];
    end

    // Handshake: a stage register loads whenever it is empty or its occupant
    // leaves this cycle (ld); it takes new data only when the stage before it
    // (or the input port) holds a valid op (fd). A transfer happens on any edge
    // where valid && ready. ld never depends on in_valid.
    genvar s, j;
    for (j = 1; j <= L; j++) begin : lv
        localparam int CS = stage_at(j - 1);
        pp_t s_in;
        if (CS >= 0) begin : from_reg
            assign s_in = hs[CS].dq.q;
        end else if (j == 1) begin : from_pre
            assign s_in = pre;
        end else begin : from_lvl
            assign s_in = lv[j-1].op.o;
        end

        if (j < L) begin : op
            localparam int DJ = 1 << (j - 1);
            localparam logic [WIDTH-1:0] LOWM = {WIDTH{1'b1}} >> (WIDTH - DJ);
            pp_t o;
            always_comb begin
                o   = s_in;
                o.g = s_in.g | (s_in.p & (s_in.g << DJ));
                o.p = s_in.p & ((s_in.p << DJ) | LOWM);
            end
        end
    end

    for (s = 0; s < STAGES; s++) begin : hs
        logic vq, ld, fd;
        if (s == STAGES - 1) begin : ld_last
            assign ld = ~vq | out_ready;
        end else begin : ld_mid
            assign ld = ~vq | hs[s+1].ld;
        end
        if (s == 0) begin : fd_in
            assign fd = in_valid;
        end else begin : fd_prev
            assign fd = hs[s-1].vq;
        end

        always_ff @(posedge clk) begin
            if (rst) vq <= 1'b0;
            else if (ld) vq <= fd;
        end

        if (s < STAGES - 1) begin : dq
            localparam int CL = cut_level(s + 1);
            pp_t q;
            if (CL == 0) begin : ld_pre
                always_ff @(posedge clk) if (ld && fd) q <= pre;
            end else begin : ld_lvl
                always_ff @(posedge clk) if (ld && fd) q <= lv[CL].op.o;
            end
        end
    end

    assign in_ready  = hs[0].ld;
    assign out_valid = hs[STAGES-1].vq;

    // Final prefix level plus sum and flags, feeding the output register.
    pp_t              f;
    logic [WIDTH-1:0] gf, carry, s_nx;
    logic             ovf_nx;
    always_comb begin
        f      = lv[L].s_in;
        gf     = f.g | (f.p & (f.g << D));
        carry  = {gf[WIDTH-2:0], f.c0};
        s_nx   = f.raw ^ carry;
        ovf_nx = ~(f.sa ^ f.sb) & (f.sa ^ s_nx[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (hs[STAGES-1].ld && hs[STAGES-1].fd) begin
            sum  <= s_nx;
            cout <= gf[WIDTH-1];
            ovf  <= ovf_nx;
            zero <= ~|s_nx;
        end
    end
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed table, streaming with random
// back-pressure, mid-flight reset, and a lockstep sweep of other WIDTH/STAGES.
module tb_pipelined_prefix_adder;
    localparam int W = 16;
    localparam int S = 2;
    localparam int NX = 5;
    localparam int XW [NX] = '{16, 16, 16, 4, 64};
    localparam int XS [NX] = '{1, 3, 5, 2, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] term0, term1, sum;

    pipelined_prefix_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .term0(term0), .term1(term1), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    logic        x_valid, x_cin, x_sub;
    logic [63:0] x_a, x_b;
    logic [NX-1:0] xo_valid, xo_ready, xo_cout, xo_ovf, xo_zero;
    logic [63:0] xo_sum [NX];

    for (genvar g = 0; g < NX; g++) begin : xd
        localparam int XWG = XW[g];
        localparam int XSG = XS[g];
        logic [XWG-1:0] s_o;
        logic co, ov, z, v, r;
        pipelined_prefix_adder #(.WIDTH(XWG), .STAGES(XSG)) u_x (
            .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r),
            .term0(x_a[XWG-1:0]), .term1(x_b[XWG-1:0]), .cin(x_cin), .sub(x_sub),
            .out_valid(v), .out_ready(1'b1),
            .sum(s_o), .cout(co), .ovf(ov), .zero(z)
        );
        assign xo_sum[g]   = 64'(s_o);
        assign xo_valid[g] = v;
        assign xo_ready[g] = r;
        assign xo_cout[g]  = co;
        assign xo_ovf[g]   = ov;
        assign xo_zero[g]  = z;
    end

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    bit lat_on = 1'b1;
    logic [66:0] exp_q[$];
    int          t_q[$];
    logic [66:0] xq [NX][$];
    int          xt [NX][$];

    typedef struct {
        logic [15:0] a, b;
        logic        ci, sb;
        logic [15:0] s;
        logic        co, ov, z;
    } vec_t;
    vec_t tbl [8];

    // Reference: {cout, ovf, zero, sum} from plain wide arithmetic.
    function automatic logic [66:0] model(input logic [63:0] a, b, input logic ci, sb, input int w);
        logic [64:0] m, full;
        logic [63:0] bb, s_v;
        logic        c0, co, ov;
        m    = (65'd1 << w) - 65'd1;
        bb   = sb ? ~b : b;
        c0   = ci ^ sb;
        full = ({1'b0, a} & m) + ({1'b0, bb} & m) + 65'(c0);
        s_v  = full[63:0] & m[63:0];
        co   = full[w];
        ov   = (a[w-1] == bb[w-1]) && (s_v[w-1] != a[w-1]);
        return {co, ov, (s_v == 64'd0), s_v};
    endfunction

    task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick(input logic iv, input logic [W-1:0] a, b, input logic ci, sb,
                        input logic ordy, input logic [66:0] e);
        @(negedge clk);
        in_valid = iv; term0 = a; term1 = b; cin = ci; sub = sb; out_ready = ordy;
        #1;
        cyc++;
        chk("in_ready", 67'(in_ready), 67'((exp_q.size() < S) || ordy));
        if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", 67'(out_valid), 67'd0);
            else begin
                chk("result", {cout, ovf, zero, 48'd0, sum}, exp_q[0]);
                if (ordy) begin
                    if (lat_on) chk("latency", 67'(cyc - t_q[0]), 67'(S));
                    void'(exp_q.pop_front());
                    void'(t_q.pop_front());
                end
            end
        end
        if (iv && in_ready) begin
            exp_q.push_back(e);
            t_q.push_back(cyc);
        end
    endtask

    task automatic idle(input logic ordy);
        tick(1'b0, '0, '0, 1'b0, 1'b0, ordy, '0);
    endtask

    task automatic rnd_op(input logic ordy);
        logic [W-1:0] a, b;
        logic ci, sb;
        a  = W'($urandom);
        b  = W'($urandom);
        ci = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        tick(1'b1, a, b, ci, sb, ordy, model(64'(a), 64'(b), ci, sb, W));
    endtask

    task automatic xtick(input logic iv, input logic [63:0] a, b, input logic ci, sb);
        @(negedge clk);
        x_valid = iv; x_a = a; x_b = b; x_cin = ci; x_sub = sb;
        #1;
        cyc++;
        for (int g = 0; g < NX; g++) begin
            chk($sformatf("x%0d_in_ready", g), 67'(xo_ready[g]), 67'd1);
            if (xo_valid[g]) begin
                if (xq[g].size() == 0) chk($sformatf("x%0d_unexpected", g), 67'(xo_valid[g]), 67'd0);
                else begin
                    chk($sformatf("x%0d_result", g),
                        {xo_cout[g], xo_ovf[g], xo_zero[g], xo_sum[g]}, xq[g][0]);
                    chk($sformatf("x%0d_latency", g), 67'(cyc - xt[g][0]), 67'(XS[g]));
                    void'(xq[g].pop_front());
                    void'(xt[g].pop_front());
                end
            end
            if (iv) begin
                xq[g].push_back(model(a, b, ci, sb, XW[g]));
                xt[g].push_back(cyc);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; term0 = '0; term1 = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0; x_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 67'(out_valid), 67'd0);
        chk("rst_outputs", {cout, ovf, zero, 48'd0, sum}, 67'd0);
        chk("rst_in_ready", 67'(in_ready), 67'd1);

        // Directed vectors, each isolated so latency is measured from an empty pipe.
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, 1'b1,
                 {tbl[i].co, tbl[i].ov, tbl[i].z, 48'd0, tbl[i].s});
            repeat (S + 1) idle(1'b1);
        end

        // Full-throughput stream.
        for (int i = 0; i < 100; i++) rnd_op(1'b1);
        repeat (S + 1) idle(1'b1);

        // Random back-pressure and random input gaps.
        lat_on = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) != 0) rnd_op(1'($urandom_range(0, 1)));
            else idle(1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1);
        chk("drain_empty", 67'(exp_q.size()), 67'd0);

        // Reset with the pipe full; rst must win over the simultaneous handshake.
        tick(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, model(64'h1111, 64'h2222, 1'b0, 1'b0, W));
        tick(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, model(64'h3333, 64'h4444, 1'b0, 1'b0, W));
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 67'(out_valid), 67'd0);
        chk("midrst_outputs", {cout, ovf, zero, 48'd0, sum}, 67'd0);
        exp_q.delete();
        t_q.delete();

        lat_on = 1'b1;
        tick(1'b1, 16'h00FF, 16'h0F0F, 1'b1, 1'b0, 1'b1, model(64'h00FF, 64'h0F0F, 1'b1, 1'b0, W));
        repeat (S + 1) idle(1'b1);
        chk("post_rst_drained", 67'(exp_q.size()), 67'd0);

        // Lockstep sweep: low nibbles enumerate every 4-bit case, upper bits random.
        for (int i = 0; i < 1024; i++) begin
            logic [63:0] a, b;
            logic [9:0]  iv;
            iv = 10'(i);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            a[3:0] = iv[3:0];
            b[3:0] = iv[7:4];
            xtick(1'b1, a, b, iv[8], iv[9]);
        end
        repeat (8) xtick(1'b0, '0, '0, 1'b0, 1'b0);
        for (int g = 0; g < NX; g++) chk($sformatf("x%0d_drained", g), 67'(xq[g].size()), 67'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational prefix adder.
- WIDTH-bit Kogge-Stone parallel-prefix adder/subtractor.
- Prefix levels are split across STAGES register stages, with a valid/ready handshake on both sides.
- Used as the datapath add/sub primitive wherever a single-cycle carry chain misses timing.

Parameters:
- WIDTH, 16, operand/sum width; power of two, 4..64.
- STAGES, 2, register stages from input acceptance to output; 1..clog2(WIDTH)+1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- term0  input  WIDTH  operand A.
- term1  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: A+B+cin; 1: A-B-cin.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the raw addition (sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset:
  - Clock edge with rst=1 clears all stage valid bits.
  - out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - In-flight operations are discarded; rst dominates any simultaneous handshake.
- Transfers:
  - Input transfer occurs on a clock edge with in_valid && in_ready.
  - Output transfer occurs on a clock edge with out_valid && out_ready.
- Preprocess, on input data:
  - B' = sub ? ~term1 : term1.
  - c0 = sub ? ~cin : cin.
  - p[i] = A[i]^B'[i], g[i] = A[i]&B'[i].
  - p (propagate) is XOR, not OR; sum[i] = p[i]^c[i].
- Prefix network:
  - clog2(WIDTH) Kogge-Stone levels.
  - Operator: (G,P) = (g_hi | p_hi&g_lo, p_hi&p_lo).
  - c0 is folded in as generate at position -1.
- Pipeline placement:
  - Logical levels 0..L, where L = clog2(WIDTH); level 0 is preprocess, the final level is sum/flags.
  - Register boundary k (1..STAGES-1) sits after level floor(k*(L+1)/STAGES)-1.
  - The final output register is always present.
  - Every boundary carries the full p, g (or G, P), the raw propagate vector, sign bits A[W-1] and B'[W-1], and a valid bit.
- Flags, computed in the last stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry-in(W-1) ^ cout.
  - zero = ~|sum.
- Latency: result of an input transfer at edge n is visible with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles.
- Handshake:
  - Per-stage register loads when its valid is 0 or the next stage takes its contents this cycle.
  - in_ready = ~v[0] | advance[0], combinational from the out_ready chain; there is no combinational path from in_valid to in_ready.
  - Full throughput: one op/cycle while out_ready=1.
  - While out_valid && ~out_ready, sum/cout/ovf/zero hold stable.
  - Bubbles collapse: a downstream hole is filled even while out_ready=0.
  - Stage registers do not load when empty and not fed; contents are don't-care when valid=0, but outputs are cleared only by reset.
- Order: strictly FIFO; no reordering, no drops, no duplicates.
- Capacity: exactly STAGES ops in flight. With out_ready low and the pipe full, in_ready=0.

Test Plan:
- WIDTH=16, STAGES=2, add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0, out_valid 2 cycles after acceptance.
- Add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1, zero=0. Add 0x1234+0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- Sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000-0x0001, cin=0 -> sum=0x7FFF, cout=1, ovf=1.
- Stream 100 random ops with in_valid=1 and out_ready=1 -> one result per cycle, matching the reference model, in order. Repeat with random out_ready (50%) -> no loss or duplication, outputs stable while stalled, in_ready=0 once 2 ops are queued.
- Assert rst for one cycle with 2 ops in flight -> next cycle out_valid=0 and all outputs 0. The first op after reset returns the correct result with STAGES latency.
- Sweep STAGES in {1,3,5} at WIDTH=16 and WIDTH in {4,64} at STAGES=2 -> latency equals STAGES and exhaustive (WIDTH=4) / random (64) results match.
